// File: rtl/fir3_mac_seq_if.sv
// fir3_mac_seq_if: sample/coefficient inputs, history-register taps and filter outputs of fir3_mac_seq.
interface fir3_mac_seq_if #(
    parameter int N = 25
);
    logic           start;
    logic [2*N-1:0] x_in;
    logic [2*N-1:0] b0;
    logic [2*N-1:0] b1;
    logic [2*N-1:0] b2;
    logic [2*N-1:0] fk;
    logic [2*N-1:0] fk_1;
    logic [2*N-1:0] fk_2;
    logic [2*N-1:0] sr_in;
    logic           shift;
    logic [2*N-1:0] y_out;
    logic           y_valid;
    logic           busy;

    modport master (
        output start, x_in, b0, b1, b2, fk, fk_1, fk_2,
        input  sr_in, shift, y_out, y_valid, busy
    );

    modport slave (
        input  start, x_in, b0, b1, b2, fk, fk_1, fk_2,
        output sr_in, shift, y_out, y_valid, busy
    );
endinterface

// File: rtl/fir3_mac_seq.sv
// fir3_mac_seq: drives a 3-tap history register and computes y = b0*fk + b1*fk_1 + b2*fk_2
// with one shared multiplier over three MAC cycles, saturating the result to 2N bits.
module fir3_mac_seq #(
    parameter int N = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    fir3_mac_seq_if.slave    bus
);
    localparam int W  = 2 * N;
    localparam int AW = 3 * N + 2;
    localparam logic signed [AW-1:0] Y_MAX = {{(N + 3){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [AW-1:0] Y_MIN = {{(N + 3){1'b1}}, {(W - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, MAC0, MAC1, MAC2, DONE} state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          sr_in_q, sr_in_d;
    logic [W-1:0]          b0_q, b0_d;
    logic [W-1:0]          b1_q, b1_d;
    logic [W-1:0]          b2_q, b2_d;
    logic [W-1:0]          y_q, y_d;
    logic                  shift_q, shift_d;
    logic                  y_valid_q, y_valid_d;
    logic                  busy_q, busy_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [AW-1:0]  sum;
    logic signed [W-1:0]   mul_c, mul_t;
    logic signed [4*N-1:0] prod;
    logic                  unused_lo;

    // Shared multiplier: coefficient/tap pair chosen by the MAC phase.
    always_comb begin
        mul_c     = state_q == MAC0 ? b0_q    : state_q == MAC1 ? b1_q      : b2_q;
        mul_t     = state_q == MAC0 ? bus.fk  : state_q == MAC1 ? bus.fk_1  : bus.fk_2;
        prod      = mul_c * mul_t;
        unused_lo = ^prod[N-1:0];
        sum       = acc_q + {{2{prod[4*N-1]}}, prod[N +: 3*N]};
    end

    always_comb begin
        state_d   = state_q;
        sr_in_d   = sr_in_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    sr_in_d = bus.x_in;
                    b0_d    = bus.b0;
                    b1_d    = bus.b1;
                    b2_d    = bus.b2;
                end
            end
            LOAD: begin
                state_d = SETTLE;
                acc_d   = '0;
            end
            SETTLE: state_d = MAC0;
            MAC0: begin
                state_d = MAC1;
                acc_d   = sum;
            end
            MAC1: begin
                state_d = MAC2;
                acc_d   = sum;
            end
            MAC2: begin
                // Final sum is saturated here so y_out and y_valid appear together in DONE.
                state_d   = DONE;
                acc_d     = sum;
                y_d       = sum > Y_MAX ? Y_MAX[W-1:0] : sum < Y_MIN ? Y_MIN[W-1:0] : sum[W-1:0];
                y_valid_d = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        shift_d = state_d == LOAD;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_in_q   <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            shift_q   <= 1'b0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_in_q   <= sr_in_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            shift_q   <= shift_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.sr_in   = sr_in_q;
    assign bus.shift   = shift_q;
    assign bus.y_out   = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = busy_q;
endmodule
